// File: rtl/bshifter_mac_ctrl.sv
// Shift/multiply service unit: one shared 16-bit barrel shifter, round-robin between two requesters,
// single-pass SHL and iterative shift-add MUL. Optional macro SKIP_ZERO_EN visits only the set bits of b.

module bshifter16 (
  input  logic [15:0] a,
  input  logic [3:0]  n,
  output logic [15:0] sho
);

  logic [15:0] stg1_s;
  logic [15:0] stg2_s;
  logic [15:0] stg4_s;

  // Four log-stages of left shift with zero fill
  always_comb begin
    if (n[0]) begin
      stg1_s = {a[14:0], 1'b0};
    end else begin
      stg1_s = a;
    end
    if (n[1]) begin
      stg2_s = {stg1_s[13:0], 2'b00};
    end else begin
      stg2_s = stg1_s;
    end
    if (n[2]) begin
      stg4_s = {stg2_s[11:0], 4'h0};
    end else begin
      stg4_s = stg2_s;
    end
    if (n[3]) begin
      sho = {stg4_s[7:0], 8'h00};
    end else begin
      sho = stg4_s;
    end
  end

endmodule

module bshifter_mac_ctrl #(
  parameter int W       = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [W-1:0] resp_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

`ifdef SKIP_ZERO_EN
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (v[k]) begin
        idx = k[3:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Returns {found, index} of the lowest set bit strictly above cur
  function automatic logic [4:0] next_set_above(input logic [15:0] v, input logic [3:0] cur);
    logic [4:0] res;
    res = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      if (v[k] && (k > int'(cur))) begin
        res = {1'b1, k[3:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction
`endif

  state_t      state_r;
  state_t      state_s;
  logic        ptr_r;
  logic        op_r;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] acc_r;
  logic [3:0]  i_r;

  logic        sel_s;
  logic        accept_s;
  logic        sel_op_s;
  logic [15:0] sel_a_s;
  logic [15:0] sel_b_s;
  logic [3:0]  sh_n_s;
  logic [15:0] sh_o_s;
  logic [15:0] acc_add_s;
  logic        last_s;
  logic [3:0]  i_next_s;
  logic [3:0]  i_first_s;

  bshifter16 u_shifter (
    .a   (a_r),
    .n   (sh_n_s),
    .sho (sh_o_s)
  );

  // Arbitration, request mux and MUL step control
  always_comb begin
    if (req0_valid && req1_valid) begin
      sel_s = ptr_r;
    end else begin
      sel_s = req1_valid;
    end
    req0_ready = (state_r == ST_IDLE) && req0_valid && (sel_s == 1'b0);
    req1_ready = (state_r == ST_IDLE) && req1_valid && (sel_s == 1'b1);
    accept_s   = req0_ready || req1_ready;
    if (sel_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
    if (op_r) begin
      sh_n_s = i_r;
    end else begin
      sh_n_s = b_r[3:0];
    end
    if (b_r[i_r]) begin
      acc_add_s = acc_r + sh_o_s;
    end else begin
      acc_add_s = acc_r;
    end
`ifdef SKIP_ZERO_EN
    {last_s, i_next_s} = next_set_above(b_r, i_r);
    last_s    = ~last_s;
    i_first_s = lowest_set(sel_b_s);
`else
    last_s    = (i_r == 4'd15);
    i_next_s  = i_r + 4'd1;
    i_first_s = 4'd0;
`endif
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_EXEC;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (!op_r || last_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        if (resp_valid && resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= RR_INIT;
      op_r       <= 1'b0;
      a_r        <= 16'h0000;
      b_r        <= 16'h0000;
      acc_r      <= 16'h0000;
      i_r        <= 4'd0;
      resp_valid <= 1'b0;
      resp_data  <= 16'h0000;
      resp_id    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= sel_op_s;
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            resp_id <= sel_s;
            ptr_r   <= ~sel_s;
            acc_r   <= 16'h0000;
            i_r     <= i_first_s;
          end
        end
        ST_EXEC: begin
          if (!op_r) begin
            resp_data <= b_r[4] ? 16'h0000 : sh_o_s;
          end else begin
            acc_r <= acc_add_s;
            i_r   <= i_next_s;
            if (last_s) begin
              resp_data <= acc_add_s;
            end
          end
        end
        ST_RESP: begin
          // Valid rises one cycle after entering RESP, drops on the handshake
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

endmodule
